// File: rtl/seq_multicycle_core.sv
// Multi-cycle sequential core: FETCH/DECODE/EXEC/MEM/WB with handshaked instruction
// and data memory ports, parametrised width and reset PC, sticky halt-on-error flags.
module seq_multicycle_core #(
  parameter int unsigned     XLEN           = 64,
  parameter logic [XLEN-1:0] RESET_PC       = '0,
  parameter int unsigned     REG_INIT_INDEX = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [31:0]     instr,
  input  logic            instr_valid,
  output logic            instr_ready,
  output logic [XLEN-1:0] pc,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ack,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            retire,
  output logic            halted,
  output logic            illegal,
  output logic            addr_error
);

  localparam logic [2:0]      LS_F3      = (XLEN == 64) ? 3'b011 : 3'b010;
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(XLEN / 8 - 1);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  state_t state, state_next;

  logic [31:0]     ir;
  logic [XLEN-1:0] op_a, op_b, imm, imm_dec, alu_out, wb_data;
  logic [XLEN-1:0] regs [32];

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd, rs1, rs2;
  logic       is_r, is_addi, is_load, is_store, is_beq, legal, misaligned;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];

  assign is_r     = (opcode == 7'b0110011) &&
                    ((funct3 == 3'b000 && (funct7 == 7'b0000000 || funct7 == 7'b0100000)) ||
                     ((funct3 == 3'b111 || funct3 == 3'b110) && funct7 == 7'b0000000));
  assign is_addi  = (opcode == 7'b0010011) && (funct3 == 3'b000);
  assign is_load  = (opcode == 7'b0000011) && (funct3 == LS_F3);
  assign is_store = (opcode == 7'b0100011) && (funct3 == LS_F3);
  assign is_beq   = (opcode == 7'b1100011) && (funct3 == 3'b000);
  assign legal    = is_r | is_addi | is_load | is_store | is_beq;

  always_comb begin
    imm_dec = {{(XLEN-12){ir[31]}}, ir[31:20]};
    if (is_store)
      imm_dec = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
    else if (is_beq)
      imm_dec = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  end

  // ADDI, load and store all use op_a + imm; BEQ compares via subtraction.
  always_comb begin
    alu_out = op_a + imm;
    if (is_r) begin
      unique case (funct3)
        3'b111:  alu_out = op_a & op_b;
        3'b110:  alu_out = op_a | op_b;
        default: alu_out = funct7[5] ? (op_a - op_b) : (op_a + op_b);
      endcase
    end else if (is_beq) begin
      alu_out = op_a - op_b;
    end
  end

  assign misaligned  = |(alu_out & ALIGN_MASK);
  assign instr_ready = (state == S_FETCH);
  assign dmem_req    = (state == S_MEM);
  assign halted      = (state == S_HALT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_FETCH;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_FETCH:  if (instr_valid) state_next = S_DECODE;
      S_DECODE: state_next = legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (is_load || is_store) state_next = misaligned ? S_HALT : S_MEM;
        else if (is_beq)         state_next = S_FETCH;
        else                     state_next = S_WB;
      end
      S_MEM:    if (dmem_ack) state_next = is_load ? S_WB : S_FETCH;
      S_WB:     state_next = S_FETCH;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc         <= RESET_PC;
      ir         <= '0;
      op_a       <= '0;
      op_b       <= '0;
      imm        <= '0;
      wb_data    <= '0;
      result     <= '0;
      zero       <= 1'b0;
      retire     <= 1'b0;
      illegal    <= 1'b0;
      addr_error <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      for (int unsigned i = 0; i < 32; i++)
        regs[i] <= (REG_INIT_INDEX != 0) ? XLEN'(i) : '0;
    end else begin
      retire <= 1'b0;
      unique case (state)
        S_FETCH: if (instr_valid) ir <= instr;
        S_DECODE: begin
          op_a <= regs[rs1];
          op_b <= regs[rs2];
          imm  <= imm_dec;
          if (!legal) illegal <= 1'b1;
        end
        S_EXEC: begin
          zero <= (alu_out == '0);
          if (is_load || is_store) begin
            if (misaligned) begin
              addr_error <= 1'b1;
            end else begin
              dmem_addr  <= alu_out;
              dmem_we    <= is_store;
              dmem_wdata <= op_b;
            end
          end else if (is_beq) begin
            pc     <= (op_a == op_b) ? (pc + imm) : (pc + XLEN'(4));
            retire <= 1'b1;
          end else begin
            wb_data <= alu_out;
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            if (is_load) begin
              wb_data <= dmem_rdata;
            end else begin
              pc     <= pc + XLEN'(4);
              retire <= 1'b1;
            end
          end
        end
        S_WB: begin
          if (rd != '0) begin
            regs[rd] <= wb_data;
            result   <= wb_data;
          end
          pc     <= pc + XLEN'(4);
          retire <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multicycle_core.sv
// Directed bench: one 64-bit and one 32-bit core share stimulus; the idle one is held in
// reset and sel picks which core's outputs are observed.
module tb_seq_multicycle_core;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst64, rst32, sel;
  logic [31:0] instr;
  logic        instr_valid, dmem_ack;
  logic [63:0] dmem_rdata;

  logic        rdy64, req64, we64, zero64, ret64, halt64, ill64, aerr64;
  logic [63:0] pc64, addr64, wdata64, res64;
  logic        rdy32, req32, we32, zero32, ret32, halt32, ill32, aerr32;
  logic [31:0] pc32, addr32, wdata32, res32;

  int checks = 0;
  int errors = 0;

  seq_multicycle_core #(.XLEN(64), .RESET_PC(64'h0), .REG_INIT_INDEX(1)) dut64 (
    .clk(clk), .reset_n(rst64), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(rdy64), .pc(pc64), .dmem_req(req64), .dmem_we(we64),
    .dmem_addr(addr64), .dmem_wdata(wdata64), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .result(res64), .zero(zero64), .retire(ret64),
    .halted(halt64), .illegal(ill64), .addr_error(aerr64)
  );

  seq_multicycle_core #(.XLEN(32), .RESET_PC(32'h40), .REG_INIT_INDEX(1)) dut32 (
    .clk(clk), .reset_n(rst32), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(rdy32), .pc(pc32), .dmem_req(req32), .dmem_we(we32),
    .dmem_addr(addr32), .dmem_wdata(wdata32), .dmem_rdata(dmem_rdata[31:0]),
    .dmem_ack(dmem_ack), .result(res32), .zero(zero32), .retire(ret32),
    .halted(halt32), .illegal(ill32), .addr_error(aerr32)
  );

  logic        o_ready, o_req, o_we, o_zero, o_retire, o_halted, o_illegal, o_aerr;
  logic [63:0] o_pc, o_addr, o_wdata, o_result;

  assign o_ready   = sel ? rdy32  : rdy64;
  assign o_req     = sel ? req32  : req64;
  assign o_we      = sel ? we32   : we64;
  assign o_zero    = sel ? zero32 : zero64;
  assign o_retire  = sel ? ret32  : ret64;
  assign o_halted  = sel ? halt32 : halt64;
  assign o_illegal = sel ? ill32  : ill64;
  assign o_aerr    = sel ? aerr32 : aerr64;
  assign o_pc      = sel ? {32'h0, pc32}    : pc64;
  assign o_addr    = sel ? {32'h0, addr32}  : addr64;
  assign o_wdata   = sel ? {32'h0, wdata32} : wdata64;
  assign o_result  = sel ? {32'h0, res32}   : res64;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL xlen=%0d %s observed=%0h expected=%0h", sel ? 32 : 64, tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    instr_valid = 1'b0;
    dmem_ack    = 1'b0;
    rst64 = 1'b0;
    rst32 = 1'b0;
    repeat (2) @(negedge clk);
    if (sel) rst32 = 1'b1;
    else     rst64 = 1'b1;
  endtask

  task automatic fetch(input logic [31:0] w);
    int n = 0;
    while (!o_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    instr       = w;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic wait_retire(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!o_retire && cyc < 20);
    if (!o_retire) cyc = -1;
  endtask

  task automatic step_alu(input string tag, input logic [31:0] w,
                          input logic [63:0] exp_res, input logic [63:0] exp_pc);
    int cyc;
    fetch(w);
    wait_retire(cyc);
    check({tag, "_latency"}, 64'(cyc), 64'd3);
    check({tag, "_result"}, o_result, exp_res);
    check({tag, "_pc"}, o_pc, exp_pc);
  endtask

  task automatic mem_txn(input int waits, input logic [63:0] rd, output int hi,
                         output logic [63:0] addr, output logic [63:0] wdata, output logic we);
    int n = 0;
    hi = 0;
    addr = '0;
    wdata = '0;
    we = 1'b0;
    while (!o_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    while (o_req && hi < 20) begin
      hi++;
      if (hi == 1) begin
        addr  = o_addr;
        wdata = o_wdata;
        we    = o_we;
      end
      if (hi > waits) begin
        dmem_ack   = 1'b1;
        dmem_rdata = rd;
      end
      @(negedge clk);
    end
    dmem_ack = 1'b0;
  endtask

  initial begin
    logic [63:0] mask, rpc, a, wd;
    logic [31:0] sw_i, lw_i, mis_i;
    logic        we, saw_req;
    int          hi, cyc, n;

    instr = '0; instr_valid = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
    sel = 1'b0; rst64 = 1'b0; rst32 = 1'b0;

    for (int s = 0; s < 2; s++) begin
      sel   = s[0];
      mask  = sel ? 64'hFFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
      rpc   = sel ? 64'h40 : 64'h0;
      sw_i  = sel ? 32'h0021_2323 : 32'h0021_3323;
      lw_i  = sel ? 32'h0061_2383 : 32'h0061_3383;
      mis_i = sel ? 32'h0060_2383 : 32'h0040_3383;

      do_reset();
      check("rst_pc", o_pc, rpc);
      check("rst_ready", 64'(o_ready), 64'd1);
      check("rst_flags", {58'd0, o_req, o_retire, o_halted, o_illegal, o_aerr, o_zero}, 64'd0);
      check("rst_result", o_result, 64'd0);

      step_alu("add", 32'h0020_81B3, 64'd3, rpc + 4);
      @(negedge clk);
      check("retire_pulse", 64'(o_retire), 64'd0);
      step_alu("addi_m1", 32'hFFF0_0293, mask, rpc + 8);
      step_alu("sub", 32'h4052_8333, 64'd0, rpc + 12);
      check("sub_zero", 64'(o_zero), 64'd1);
      step_alu("addi_x0", 32'h0070_0013, 64'd0, rpc + 16);
      step_alu("x0_read", 32'h0010_0433, 64'd1, rpc + 20);
      step_alu("or", 32'h0020_E4B3, 64'd3, rpc + 24);
      step_alu("and", 32'h0021_F533, 64'd2, rpc + 28);

      fetch(sw_i);
      mem_txn(3, 64'd0, hi, a, wd, we);
      check("st_req_cycles", 64'(hi), 64'd4);
      check("st_addr", a, 64'd8);
      check("st_wdata", wd, 64'd2);
      check("st_we", 64'(we), 64'd1);
      check("st_retire", 64'(o_retire), 64'd1);
      check("st_pc", o_pc, rpc + 32);

      fetch(lw_i);
      mem_txn(0, 64'hAB, hi, a, wd, we);
      check("ld_req_cycles", 64'(hi), 64'd1);
      check("ld_addr_we", {a[62:0], we}, {63'd8, 1'b0});
      @(negedge clk);
      check("ld_retire", 64'(o_retire), 64'd1);
      check("ld_result", o_result, 64'hAB);
      check("ld_pc", o_pc, rpc + 36);

      fetch(32'h0010_8863);
      wait_retire(cyc);
      check("beq_t_latency", 64'(cyc), 64'd2);
      check("beq_t_pc", o_pc, rpc + 52);
      fetch(32'h0020_8863);
      wait_retire(cyc);
      check("beq_nt_pc", o_pc, rpc + 56);
      check("beq_result", o_result, 64'hAB);
      fetch(32'hFE00_0CE3);
      wait_retire(cyc);
      check("beq_back_pc", o_pc, rpc + 48);

      fetch(mis_i);
      saw_req = 1'b0;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        saw_req = saw_req | o_req;
      end
      check("mis_flags", {59'd0, o_aerr, o_halted, o_illegal, o_ready, saw_req}, 64'b11000);
      check("mis_pc", o_pc, rpc + 48);

      do_reset();
      step_alu("addi_x1", 32'h0050_0093, 64'd5, rpc + 4);
      fetch(sw_i);
      n = 0;
      while (!o_req && n < 10) begin
        @(negedge clk);
        n++;
      end
      check("mid_mem_req", 64'(o_req), 64'd1);
      if (sel) rst32 = 1'b0;
      else     rst64 = 1'b0;
      #1;
      check("rst_mem_req", 64'(o_req), 64'd0);
      check("rst_mem_pc", o_pc, rpc);
      @(negedge clk);
      if (sel) rst32 = 1'b1;
      else     rst64 = 1'b1;
      dmem_ack = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("late_ack", {60'd0, o_req, o_retire, o_ready, o_halted}, 64'b0010);
      check("late_ack_pc", o_pc, rpc);
      dmem_ack = 1'b0;
      step_alu("regs_reinit", 32'h0020_81B3, 64'd3, rpc + 4);

      fetch(32'hFFFF_FFFF);
      instr       = 32'h0020_81B3;
      instr_valid = 1'b1;
      repeat (4) @(negedge clk);
      check("ill_flags", {60'd0, o_illegal, o_halted, o_ready, o_aerr}, 64'b1100);
      check("ill_pc", o_pc, rpc + 4);
      instr_valid = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_multicycle_core.md
# seq_multicycle_core

Parametrised multi-cycle successor to the single-cycle sequential datapath. It runs one instruction at a time through an explicit FETCH/DECODE/EXEC/MEM/WB state machine. Instruction and data memories are reached through valid/ready and req/ack handshakes with arbitrary wait states. Data width, reset PC and register-file reset pattern are parameters. Illegal opcodes and misaligned accesses halt the core with sticky error flags.

## Interface
- XLEN, 64 — datapath width; legal values 32 or 64.
- RESET_PC, 0 — PC value loaded on reset; must be a multiple of 4.
- REG_INIT_INDEX, 1 — 1: register xi resets to i; 0: all registers reset to 0 (x0 is always 0).
- clk  input  1  — single clock; all state updates on rising edge.
- reset_n  input  1  — asynchronous, active-low reset.
- instr  input  32  — instruction word for the current pc.
- instr_valid  input  1  — instr is valid.
- instr_ready  output  1  — core is accepting an instruction (FETCH only).
- pc  output  XLEN  — address of the current instruction.
- dmem_req  output  1  — data memory request; held until acknowledged.
- dmem_we  output  1  — 1 for store, 0 for load; valid with dmem_req.
- dmem_addr  output  XLEN  — effective address rs1 + sext(imm).
- dmem_wdata  output  XLEN  — store data (rs2).
- dmem_rdata  input  XLEN  — load data; sampled on dmem_ack.
- dmem_ack  input  1  — completes the request.
- result  output  XLEN  — write-back value; registered, updated on every retire that writes rd.
- zero  output  1  — registered: ALU result == 0 from the last EXEC.
- retire  output  1  — one-cycle pulse per completed instruction.
- halted  output  1  — core is in HALT.
- illegal  output  1  — sticky: unsupported instruction decoded.
- addr_error  output  1  — sticky: misaligned data access.

## Operation
- Supported instructions:
  - R-type (opcode 0110011): ADD, SUB (funct7 0100000), AND, OR.
  - ADDI (0010011, funct3 000).
  - Load (0000011) and store (0100011): funct3 011 when XLEN=64, 010 when XLEN=32.
  - BEQ (1100011, funct3 000).
  - Any other encoding is illegal.
- Immediates are sign-extended to XLEN. Arithmetic is modulo 2^XLEN; no carry or overflow outputs.
- FETCH: instr_ready=1. The instruction is captured when instr_valid && instr_ready; next state DECODE. Otherwise stay in FETCH.
- DECODE: read rs1/rs2, form the immediate. Illegal encoding: set illegal, go to HALT. Otherwise go to EXEC.
- EXEC: compute ALU result / effective address / branch compare.
  - R-type and ADDI go to WB.
  - Load/store: check alignment (low log2(XLEN/8) address bits must be 0). Misaligned: set addr_error, go to HALT, and assert no dmem_req. Aligned: go to MEM.
  - BEQ: pc <= pc + sext(B-imm) if equal, else pc + 4; pulse retire; go to FETCH.
- MEM: dmem_req=1, with addr/we/wdata stable until dmem_ack.
  - Load on ack: latch dmem_rdata, go to WB.
  - Store on ack: pc += 4, pulse retire, go to FETCH.
- WB: if rd != 0, write rd and update result; pc += 4; pulse retire; go to FETCH.
- HALT: absorbing; pc frozen; instr_ready=0, dmem_req=0. Left only by reset.
- Writes to x0 are discarded; x0 reads 0.
- Reset (any state, including mid-MEM):
  - state=FETCH, pc=RESET_PC; registers per REG_INIT_INDEX.
  - result=0, zero=0, retire=0, halted=0, illegal=0, addr_error=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, instr_ready=1.
  - An outstanding dmem request is abandoned; a late dmem_ack is ignored.

## Timing
- Minimum cycles from fetch handshake to retire:
  - R/ADDI: 3 (DECODE, EXEC, WB).
  - BEQ: 2.
  - Store: 3 + wait states.
  - Load: 4 + wait states.
- dmem_ack in the first MEM cycle means zero wait states. dmem_ack outside MEM is ignored.
- retire, result, the register write and the pc update all take effect on the same edge.
- instr_valid may be held low indefinitely; the core idles in FETCH with no state change.
- The next instruction can be accepted in the cycle after the retire pulse.

## Test plan
- Reset with REG_INIT_INDEX=1, then ADD x3,x1,x2 -> retire 3 cycles after handshake, result=3, pc=RESET_PC+4.
- ADDI x5,x0,-1 (XLEN=64) -> result=0xFFFF_FFFF_FFFF_FFFF. SUB x6,x5,x5 -> result=0, zero=1. ADDI x0,x0,7 -> x0 stays 0.
- SD x2,6(x2) -> dmem_addr=8, dmem_wdata=2, dmem_we=1. With ack held off 3 cycles, dmem_req stays high 4 cycles. Then LD x7,6(x2) with rdata 0xAB -> result=0xAB.
- BEQ x1,x1,+16 at pc 0x10 -> pc=0x20. BEQ x1,x2,+16 -> pc=0x14. Neither writes result.
- Instruction 0xFFFFFFFF -> illegal=1, halted=1, instr_ready=0. LD at address 4 (XLEN=64) -> addr_error=1, no dmem_req.
- reset_n low during MEM wait -> dmem_req drops immediately, pc=RESET_PC, registers reinitialised, a late ack has no effect. Repeat all scenarios with XLEN=32 using LW/SW.
